// File: rtl/rst_req_handshake_tx.sv
// Initiator side of a cross-domain reset handshake: drives a reset request into a
// far clock domain and sequences assert -> ack high -> release -> ack low.
module rst_req_handshake_tx #(
  parameter int MIN_PULSE  = 16,
  parameter int ACK_STAGES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic clk,
  input  logic rst_i,
  input  logic req_i,
  input  logic ack_i,
  output logic rst_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o
);

  localparam int CNT_MAX = (MIN_PULSE > TIMEOUT) ? MIN_PULSE : TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ASSERT      = 2'd1,
    WAIT_ACK_HI = 2'd2,
    WAIT_ACK_LO = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_q, rst_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             ack_s;

  // ack_i is asynchronous to clk; only the last stage is used by the FSM.
  (* ASYNC_REG = "TRUE" *) logic [ACK_STAGES-1:0] ack_sync_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[ACK_STAGES-2:0], ack_i};
    end
  end

  assign ack_s = ack_sync_q[ACK_STAGES-1];

  // Local reset lands in ASSERT so every local reset also resets the far domain.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      rst_q     <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_q     <= rst_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    rst_d     = rst_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        rst_d = 1'b0;
        if (req_i) begin
          state_d   = ASSERT;
          rst_d     = 1'b1;
          timeout_d = 1'b0;
        end
      end
      ASSERT: begin
        rst_d = 1'b1;
        if (cnt_q == PULSE_LAST) begin
          state_d = WAIT_ACK_HI;
          cnt_d   = '0;
        end
      end
      WAIT_ACK_HI: begin
        rst_d = 1'b1;
        // An acknowledge on the final timeout cycle still counts as success.
        if (ack_s) begin
          state_d = WAIT_ACK_LO;
          cnt_d   = '0;
          rst_d   = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          rst_d     = 1'b0;
          timeout_d = 1'b1;
        end
      end
      WAIT_ACK_LO: begin
        rst_d = 1'b0;
        if (!ack_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rst_d   = 1'b0;
      end
    endcase
  end

  assign rst_o     = rst_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign timeout_o = timeout_q;

endmodule
